mult_seq: RTL and testbench
===========================

# mult_seq

Multi-cycle 32x32 shift-add multiplier for the MIPS32 core, paired with the existing multi-cycle divider in the HI/LO execution path. It owns the architectural HI/LO result pair and executes MULT, MULTU, MADD, MADDU, MSUB and MSUBU. Stall holds the pipeline while an operation is in flight, in the same way the divider's stall does.

## Interface
- No parameters; the data width is fixed at 32 bits.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- OP_mult  in  1  start signed multiply; HI:LO <= product
- OP_multu  in  1  start unsigned multiply; HI:LO <= product
- OP_madd  in  1  start signed multiply-add; HI:LO <= HI:LO + product
- OP_maddu  in  1  start unsigned multiply-add
- OP_msub  in  1  start signed multiply-subtract; HI:LO <= HI:LO - product
- OP_msubu  in  1  start unsigned multiply-subtract
- Multiplicand  in  32  operand A, sampled on the start edge only
- Multiplier  in  32  operand B, sampled on the start edge only
- HI  out  32  upper product/accumulator word
- LO  out  32  lower product/accumulator word
- Stall  out  1  high while an operation is in flight

## Operation
- States: IDLE, RUN, FINISH.
- Start condition: any OP_* high at a rising edge, in any state.
- On start:
  - Capture the operand magnitudes. Signed ops use the two's-complement magnitude of each operand; -2^31 yields 0x80000000, treated as unsigned.
  - Unsigned ops use the operands unchanged.
  - neg <= A[31]^B[31] for signed ops, 0 for unsigned ops.
  - Latch the op kind: set, add, or subtract.
  - prod[63:0] <= {32'b0, |B|}; cycle <= 31; state <= RUN.
- Op priority when several are high: mult > multu > madd > maddu > msub > msubu. Only the winner is executed.
- RUN, one step per edge:
  - If prod[0]: upper[32:0] = {1'b0, prod[63:32]} + |A|; otherwise upper = {1'b0, prod[63:32]}.
  - prod <= {upper, prod[31:1]}. The carry bit is kept; it shifts into bit 63.
  - cycle decrements. When cycle==0 on the edge, state <= FINISH.
- FINISH, one edge:
  - p = neg ? -prod : prod (64-bit two's complement).
  - Set: HI:LO <= p. Add: HI:LO <= HI:LO + p. Subtract: HI:LO <= HI:LO - p.
  - All arithmetic is mod 2^64; there is no overflow flag.
  - state <= IDLE.
- HI/LO change only on a FINISH edge or on reset.
- Abort: a start while in RUN or FINISH discards the in-flight op. HI/LO keep their prior value, and the new op restarts from cycle 31. A start coincident with the FINISH edge wins: no writeback occurs on that edge.
- Reset: state IDLE; HI, LO, prod, cycle, neg and the op kind all become 0; Stall 0. Reset overrides any OP_* on the same edge.

## Timing
- Reset values: HI=0, LO=0, Stall=0.
- Stall = (state != IDLE), decoded from registered state with no combinational path from the OP_* inputs.
- Start sampled at edge E0:
  - Stall is high from after E0 through E33.
  - RUN occupies edges E1..E32; FINISH is edge E33.
  - HI/LO are valid, and Stall is low, in the cycle after E33.
  - Total: 33 stalled cycles.
- Back-to-back ops: a new start is legal in the first cycle Stall is low. It is also legal earlier, but then it aborts the op in flight.
- Operand inputs are don't-care except on the start edge.

## Test plan
- Unsigned extremes: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Stall is high for exactly 33 cycles after the start edge.
- Signed mixed sign: MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Signed min x min: MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
- Accumulate carry across words:
  - MULTU 0xFFFFFFFF x 1, then MADDU 1 x 1 -> HI=0x00000001, LO=0x00000000.
  - Then MSUB 2 x 3 -> HI=0x00000000, LO=0xFFFFFFFA.
- Abort: with HI:LO=0:0, MULTU 5 x 5, then MULTU 6 x 7 ten cycles later -> HI=0, LO=42. The value 25 never appears on LO. Stall stays high continuously and drops 33 cycles after the second start.
- Reset mid-op: MULT 9 x 9, assert reset on cycle 15 -> the next cycle shows Stall=0, HI=0, LO=0, and no writeback follows.

Source files
------------

// File: rtl/mult_seq.sv
// Multi-cycle 32x32 shift-add multiplier owning the HI/LO pair.
// Handles MULT/MULTU/MADD/MADDU/MSUB/MSUBU; 33 stalled cycles per operation.
module mult_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        OP_mult,
   input  logic        OP_multu,
   input  logic        OP_madd,
   input  logic        OP_maddu,
   input  logic        OP_msub,
   input  logic        OP_msubu,
   input  logic [31:0] Multiplicand,
   input  logic [31:0] Multiplier,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Stall
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
   typedef enum logic [1:0] {K_SET, K_ADD, K_SUB} kind_t;

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [63:0] hilo_q, hilo_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] mcand_q, mcand_d;
   logic [4:0]  cycle_q, cycle_d;
   logic        neg_q, neg_d;

   logic        start;
   logic        start_signed;
   kind_t       start_kind;
   logic [31:0] a_mag, b_mag;
   logic [32:0] upper;
   logic [63:0] p;

   assign start = OP_mult | OP_multu | OP_madd | OP_maddu | OP_msub | OP_msubu;

   // Priority decode: only the highest-ranked asserted op is executed.
   always_comb begin
      start_signed = 1'b0;
      start_kind   = K_SUB;
      if (OP_mult) begin
         start_signed = 1'b1;
         start_kind   = K_SET;
      end else if (OP_multu) begin
         start_kind   = K_SET;
      end else if (OP_madd) begin
         start_signed = 1'b1;
         start_kind   = K_ADD;
      end else if (OP_maddu) begin
         start_kind   = K_ADD;
      end else if (OP_msub) begin
         start_signed = 1'b1;
      end
   end

   // -2^31 negates to 0x80000000, which is the correct unsigned magnitude.
   assign a_mag = (start_signed && Multiplicand[31]) ? (~Multiplicand + 32'd1) : Multiplicand;
   assign b_mag = (start_signed && Multiplier[31])   ? (~Multiplier + 32'd1)   : Multiplier;

   assign upper = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
   assign p     = neg_q ? (~prod_q + 64'd1) : prod_q;

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      hilo_d  = hilo_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      cycle_d = cycle_q;
      neg_d   = neg_q;

      case (state_q)
         RUN: begin
            prod_d  = {upper, prod_q[31:1]};
            cycle_d = cycle_q - 5'd1;
            if (cycle_q == 5'd0)
               state_d = FINISH;
         end
         FINISH: begin
            case (kind_q)
               K_SET:   hilo_d = p;
               K_ADD:   hilo_d = hilo_q + p;
               default: hilo_d = hilo_q - p;
            endcase
            state_d = IDLE;
         end
         default: ;
      endcase

      // A new start aborts anything in flight, including a pending writeback.
      if (start) begin
         hilo_d  = hilo_q;
         mcand_d = a_mag;
         prod_d  = {32'd0, b_mag};
         neg_d   = start_signed & (Multiplicand[31] ^ Multiplier[31]);
         kind_d  = start_kind;
         cycle_d = 5'd31;
         state_d = RUN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         kind_q  <= K_SET;
         hilo_q  <= 64'd0;
         prod_q  <= 64'd0;
         mcand_q <= 32'd0;
         cycle_q <= 5'd0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         hilo_q  <= hilo_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         cycle_q <= cycle_d;
         neg_q   <= neg_d;
      end
   end

   assign HI    = hilo_q[63:32];
   assign LO    = hilo_q[31:0];
   assign Stall = (state_q != IDLE);

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: products, accumulation, priority, abort and reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_mult_seq;

   logic        clock;
   logic        reset;
   logic [5:0]  op_vec;   // [0]mult [1]multu [2]madd [3]maddu [4]msub [5]msubu
   logic [31:0] mcand, mplier;
   logic [31:0] hi, lo;
   logic        stall;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [5:0] MULT  = 6'b000001;
   localparam logic [5:0] MULTU = 6'b000010;
   localparam logic [5:0] MADD  = 6'b000100;
   localparam logic [5:0] MADDU = 6'b001000;
   localparam logic [5:0] MSUB  = 6'b010000;
   localparam logic [5:0] MSUBU = 6'b100000;

   mult_seq dut (
      .clock        (clock),
      .reset        (reset),
      .OP_mult      (op_vec[0]),
      .OP_multu     (op_vec[1]),
      .OP_madd      (op_vec[2]),
      .OP_maddu     (op_vec[3]),
      .OP_msub      (op_vec[4]),
      .OP_msubu     (op_vec[5]),
      .Multiplicand (mcand),
      .Multiplier   (mplier),
      .HI           (hi),
      .LO           (lo),
      .Stall        (stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op at the next rising edge, then count stalled cycles.
   task automatic run_op(input string tag, input logic [5:0] ops, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_hilo);
      int n;
      @(negedge clock);
      op_vec = ops;
      mcand  = a;
      mplier = b;
      @(negedge clock);
      op_vec = 6'd0;
      mcand  = $urandom;
      mplier = $urandom;
      n = 0;
      while (stall && n < 100) begin
         n++;
         @(negedge clock);
      end
      chk({tag, "_stall_cycles"}, 64'(n), 64'd33);
      chk({tag, "_hilo"}, {hi, lo}, exp_hilo);
      $display("op %s a=%h b=%h -> HI=%h LO=%h stall=%0d", tag, a, b, hi, lo, n);
   endtask

   initial begin
      int  n;
      bit  saw25;
      bit  gap;
      reset  = 1'b1;
      op_vec = MULT;   // reset must override a start on the same edge
      mcand  = 32'd3;
      mplier = 32'd3;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_stall", 64'(stall), 64'd0);
      op_vec = 6'd0;
      reset  = 1'b0;
      @(negedge clock);
      chk("idle_stall", 64'(stall), 64'd0);

      run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
      run_op("mult_neg3x7", MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
      run_op("mult_minxmin", MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
      run_op("multu_ffx1", MULTU, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
      run_op("maddu_carry", MADDU, 32'd1, 32'd1, 64'h00000001_00000000);
      run_op("msub_2x3", MSUB, 32'd2, 32'd3, 64'h00000000_FFFFFFFA);
      run_op("madd_neg2x3", MADD, 32'hFFFFFFFE, 32'd3, 64'h00000000_FFFFFFF4);
      run_op("msubu_ffx2", MSUBU, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFE_FFFFFFF6);
      run_op("prio_mult", MULT | MULTU, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE);
      run_op("prio_madd", MADD | MSUB | MSUBU, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF);

      // Reset back to 0:0 before the abort scenario.
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("reset2_hilo", {hi, lo}, 64'd0);

      // Abort: MULTU 5x5, then MULTU 6x7 ten cycles later.
      op_vec = MULTU;
      mcand  = 32'd5;
      mplier = 32'd5;
      @(negedge clock);
      op_vec = 6'd0;
      saw25  = 1'b0;
      gap    = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (!stall) gap = 1'b1;
         if (lo == 32'd25) saw25 = 1'b1;
         @(negedge clock);
      end
      if (!stall) gap = 1'b1;
      op_vec = MULTU;
      mcand  = 32'd6;
      mplier = 32'd7;
      @(negedge clock);
      op_vec = 6'd0;
      n = 0;
      while (stall && n < 100) begin
         n++;
         if (lo == 32'd25) saw25 = 1'b1;
         @(negedge clock);
      end
      chk("abort_stall_gap", 64'(gap), 64'd0);
      chk("abort_stall_cycles", 64'(n), 64'd33);
      chk("abort_hilo", {hi, lo}, 64'd42);
      chk("abort_no25", 64'(saw25), 64'd0);
      $display("op abort multu 6x7 -> HI=%h LO=%h stall=%0d", hi, lo, n);

      // Reset mid-op: MULT 9x9, reset on the 15th edge after the start.
      op_vec = MULT;
      mcand  = 32'd9;
      mplier = 32'd9;
      @(negedge clock);
      op_vec = 6'd0;
      repeat (14) @(negedge clock);
      chk("midop_stall_before", 64'(stall), 64'd1);
      chk("midop_hilo_before", {hi, lo}, 64'd42);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midop_reset_stall", 64'(stall), 64'd0);
      chk("midop_reset_hilo", {hi, lo}, 64'd0);
      repeat (40) @(negedge clock);
      chk("midop_no_wb_hilo", {hi, lo}, 64'd0);
      chk("midop_no_wb_stall", 64'(stall), 64'd0);
      $display("op reset mid-op mult 9x9 -> HI=%h LO=%h stall=%0d", hi, lo, stall);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
